// File: rtl/window_gen_5.sv
// window_gen_5: streaming 5x5 sliding-window generator for the 5x5 MAC array.
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   i_valid, i_sof     pixel strobe and start-of-frame (qualified by i_valid)
//   i_data             raster-order pixel
//   win_1..win_5       window rows, win_1 = oldest row (r-4), win_5 = current row (r);
//                      slice 1 (LSB) is column c-4, slice 5 (MSB) is column c
//   win_valid          window at an unpadded position (r>=4, c>=4)
//   frame_done         pulse after the last pixel of a frame
module window_gen_5 #(
    parameter int data_size  = 8,
    parameter int img_width  = 32,
    parameter int img_height = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic                   i_sof,
    input  logic [data_size-1:0]   i_data,
    output logic [data_size*5-1:0] win_1,
    output logic [data_size*5-1:0] win_2,
    output logic [data_size*5-1:0] win_3,
    output logic [data_size*5-1:0] win_4,
    output logic [data_size*5-1:0] win_5,
    output logic                   win_valid,
    output logic                   frame_done
);
    localparam int CW = $clog2(img_width);
    localparam int RW = $clog2(img_height);
    localparam int WW = data_size * 5;

    logic [CW-1:0]        col_q, col_d, cur_col;
    logic [RW-1:0]        row_q, row_d, cur_row;
    logic                 last_col, last_row;
    logic [data_size-1:0] lb_q [4][img_width];
    logic [data_size-1:0] col_vec [5];
    logic [WW-1:0]        win_q [5];
    logic [WW-1:0]        win_d [5];
    logic                 win_valid_q, win_valid_d, frame_done_q, frame_done_d;

    always_comb begin
        // i_sof overrides the counters so the current pixel is (0,0)
        cur_col      = i_sof ? '0 : col_q;
        cur_row      = i_sof ? '0 : row_q;
        last_col     = cur_col == CW'(img_width - 1);
        last_row     = cur_row == RW'(img_height - 1);
        col_d        = !i_valid ? col_q : last_col ? '0 : cur_col + 1'b1;
        row_d        = !i_valid ? row_q : !last_col ? cur_row : last_row ? '0 : cur_row + 1'b1;
        win_valid_d  = i_valid && cur_row >= RW'(4) && cur_col >= CW'(4);
        frame_done_d = i_valid && last_row && last_col;
        // lb_q[0] is one row back, lb_q[3] four rows back
        for (int k = 0; k < 5; k++) begin
            col_vec[k] = k < 4 ? lb_q[3-k][cur_col] : i_data;
            win_d[k]   = i_valid ? {col_vec[k], win_q[k][WW-1:data_size]} : win_q[k];
        end
    end

    // Line buffers carry no reset; stale rows are masked by the r>=4 rule.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            lb_q[3][cur_col] <= lb_q[2][cur_col];
            lb_q[2][cur_col] <= lb_q[1][cur_col];
            lb_q[1][cur_col] <= lb_q[0][cur_col];
            lb_q[0][cur_col] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 5; k++) win_q[k] <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < 5; k++) win_q[k] <= win_d[k];
        end
    end

    assign win_1      = win_q[0];
    assign win_2      = win_q[1];
    assign win_3      = win_q[2];
    assign win_4      = win_q[3];
    assign win_5      = win_q[4];
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_window_gen_5.sv
// tb_window_gen_5: scoreboard bench for window_gen_5 on an 8x6 image, pixel(r,c)=base+r*8+c.
module tb_window_gen_5;
    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_sof = 1'b0;
    logic [7:0]  i_data = '0;
    logic [39:0] win_1, win_2, win_3, win_4, win_5;
    logic        win_valid, frame_done;

    window_gen_5 #(.data_size(8), .img_width(W), .img_height(H)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
        .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4), .win_5(win_5),
        .win_valid(win_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int           cyc;
        logic         fd;
        logic [199:0] w;
    } exp_t;

    exp_t         q[$];
    int           pass_n = 0, total_n = 0, cyc = 0, wv_cnt = 0, fd_cnt = 0, mr = 0, mc = 0;
    logic         last_v = 1'b0, rst_seen = 1'b1;
    logic [199:0] snap = '0;

    task automatic chk(input string nm, input logic [199:0] a, input logic [199:0] e);
        total_n++;
        if (a === e) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    // Row k (1 = oldest) of the window ending at (r,c)
    function automatic logic [39:0] erow(int r, int c, int k, int base);
        logic [39:0] x;
        for (int j = 1; j <= 5; j++) x[8*j-1 -: 8] = 8'(base + (r - 5 + k) * W + c - 5 + j);
        return x;
    endfunction

    always @(posedge clk) begin
        cyc++;
        last_v = i_valid && rst_n;
    end

    always @(negedge rst_n) rst_seen = 1'b1;

    always @(negedge clk) begin
        logic [199:0] act;
        exp_t         e;
        act = {win_5, win_4, win_3, win_2, win_1};
        if (rst_n && !rst_seen) begin
            if (win_valid) wv_cnt++;
            if (frame_done) fd_cnt++;
            if (!last_v) begin
                chk("hold_win", act, snap);
                chk("idle_flags", 200'({win_valid, frame_done}), 200'(0));
            end else if (win_valid) begin
                if (q.size() == 0) chk("spurious_valid", 200'(1), 200'(0));
                else begin
                    e = q.pop_front();
                    chk("valid_cycle", 200'(cyc), 200'(e.cyc));
                    chk("win_1", 200'(win_1), 200'(e.w[39:0]));
                    chk("win_2", 200'(win_2), 200'(e.w[79:40]));
                    chk("win_3", 200'(win_3), 200'(e.w[119:80]));
                    chk("win_4", 200'(win_4), 200'(e.w[159:120]));
                    chk("win_5", 200'(win_5), 200'(e.w[199:160]));
                    chk("frame_done", 200'(frame_done), 200'(e.fd));
                end
            end else begin
                chk("fd_without_valid", 200'(frame_done), 200'(0));
                if (q.size() != 0 && q[0].cyc <= cyc) begin
                    chk("missed_window", 200'(win_valid), 200'(1));
                    void'(q.pop_front());
                end
            end
        end
        snap = act;
        rst_seen = !rst_n;
    end

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic px(input logic sof, input int base);
        exp_t e;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        i_valid = 1'b1;
        i_sof   = sof;
        i_data  = 8'(base + mr * W + mc);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        if (mr >= 4 && mc >= 4) begin
            e.cyc = cyc;
            e.fd  = (mr == H - 1) && (mc == W - 1);
            for (int k = 1; k <= 5; k++) e.w[40*(k-1) +: 40] = erow(mr, mc, k, base);
            q.push_back(e);
        end
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else mc++;
    endtask

    task automatic frame(input int base, input logic sof_first, input logic bub);
        for (int i = 0; i < W * H; i++) begin
            px(i == 0 && sof_first, base);
            if (i == 36 && base == 0) begin
                chk("first_valid", 200'(win_valid), 200'(1));
                chk("first_win_1", 200'(win_1), 200'(40'h0403020100));
                chk("first_win_5", 200'(win_5), 200'(40'h2423222120));
            end
            if (i == 36 && base == 100) chk("f2_first_win_5", 200'(win_5), 200'(40'h8887868584));
            if (i == 44 && base == 0) begin
                chk("rowb_win_1", 200'(win_1), 200'(40'h0C0B0A0908));
                chk("rowb_win_5", 200'(win_5), 200'(40'h2C2B2A2928));
            end
            if (bub) idle(1);
        end
    endtask

    task automatic fin(input string nm, input int w0, input int f0, input int ewv, input int efd);
        idle(3);
        chk({nm, "_wv_count"}, 200'(wv_cnt - w0), 200'(ewv));
        chk({nm, "_fd_count"}, 200'(fd_cnt - f0), 200'(efd));
        chk({nm, "_queue_empty"}, 200'(q.size()), 200'(0));
    endtask

    initial begin
        int w0, f0;
        #12;
        chk("reset_win", {win_5, win_4, win_3, win_2, win_1}, 200'(0));
        chk("reset_flags", 200'({win_valid, frame_done}), 200'(0));
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        w0 = wv_cnt; f0 = fd_cnt;
        frame(0, 1'b1, 1'b0);
        fin("s1", w0, f0, 8, 1);

        w0 = wv_cnt; f0 = fd_cnt;
        frame(0, 1'b1, 1'b1);
        fin("s2", w0, f0, 8, 1);

        w0 = wv_cnt; f0 = fd_cnt;
        frame(0, 1'b1, 1'b0);
        frame(100, 1'b0, 1'b0);
        fin("s3", w0, f0, 16, 2);

        w0 = wv_cnt; f0 = fd_cnt;
        for (int i = 0; i < 20; i++) px(i == 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_win", {win_5, win_4, win_3, win_2, win_1}, 200'(0));
        chk("midrst_flags", 200'({win_valid, frame_done}), 200'(0));
        q.delete();
        mr = 0;
        mc = 0;
        @(posedge clk);
        #3;
        chk("midrst_held_win", {win_5, win_4, win_3, win_2, win_1}, 200'(0));
        rst_n = 1'b1;
        frame(0, 1'b0, 1'b0);
        fin("s4", w0, f0, 8, 1);

        w0 = wv_cnt; f0 = fd_cnt;
        for (int i = 0; i < 30; i++) px(i == 0, 0);
        frame(0, 1'b1, 1'b0);
        fin("s5", w0, f0, 8, 1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
